// File: rtl/uart_rx_core.sv
`timescale 1ns/1ps
// Purpose : 8N1 UART receiver with glitch-rejecting start detection and mid-bit sampling.
// Latency : rx_i -> rx_s 2 cycles; stop-bit sample -> rx_valid_o 1 cycle.
// Backpr. : 1-deep holding register; a completed byte arriving while full and not
//           being accepted is dropped and flagged on overrun_o.
//
// Ports:
//   clk_i        soc_clk, all logic on its rising edge
//   rst_n_i      asynchronous active-low reset
//   rx_i         raw serial line (asynchronous, idle high)
//   rx_data_o    received byte, valid while rx_valid_o=1
//   rx_valid_o   holding register full
//   rx_ready_i   consumer accepts when rx_valid_o & rx_ready_i
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   overrun_o    1-cycle pulse: completed byte dropped (holding register full)
//   busy_o       receiver FSM not idle
module uart_rx_core #(
    parameter int unsigned CLK_DIV = 87,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Terminal counts: start bit is checked at its mid-point, which re-phases
    // every later sample (one full bit later) to the middle of its bit.
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((CLK_DIV - 1) / 2);

    // Input synchronizer and edge detect; all reset high to match the idle line
    // so reset release never looks like a start edge.
    logic sync1_q, rx_s_q, rx_d_q;
    logic fall_edge;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       byte_done;

    assign fall_edge = rx_d_q & ~rx_s_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // Receive FSM
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fall_edge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == HALF_END) begin
                    baud_d = '0;
                    bit_d  = 3'd0;
                    // Line back high by mid-start: treat as a glitch, silently.
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};  // LSB first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Leaving at the stop mid-point gives half a bit of slack to
                // catch a back-to-back start edge from IDLE.
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Holding register: a byte completing in the same cycle the old one is
    // accepted replaces it without a gap in rx_valid_o.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (byte_done) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Bench for uart_rx_core: directed frames on a CLK_DIV=8 and a CLK_DIV=87 instance,
// then a random frame mix on the CLK_DIV=8 instance against a byte-level model of
// the holding register (accepted bytes, overruns, framing errors).
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8 = 1'b1, rdy8 = 1'b0;
    logic       rx87 = 1'b1, rdy87 = 1'b0;
    logic [7:0] d8, d87;
    logic       v8, v87, fe8, fe87, ov8, ov87, bz8, bz87;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.CLK_DIV(8), .CNT_W(16)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx8), .rx_data_o(d8), .rx_valid_o(v8),
        .rx_ready_i(rdy8), .frame_err_o(fe8), .overrun_o(ov8), .busy_o(bz8)
    );

    uart_rx_core #(.CLK_DIV(87), .CNT_W(16)) dut87 (
        .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx87), .rx_data_o(d87), .rx_valid_o(v87),
        .rx_ready_i(rdy87), .frame_err_o(fe87), .overrun_o(ov87), .busy_o(bz87)
    );

    // Monitors: every accepted byte and every pulse cycle is recorded.
    logic [7:0] got8[$];
    logic [7:0] got87[$];
    int ferr8 = 0, ovr8 = 0, vld8 = 0, busy8 = 0, ferr87 = 0, ovr87 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v8 && rdy8) got8.push_back(d8);
            if (v8) vld8++;
            if (fe8) ferr8++;
            if (ov8) ovr8++;
            if (bz8) busy8++;
            if (v87 && rdy87) got87.push_back(d87);
            if (fe87) ferr87++;
            if (ov87) ovr87++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input bit is87, input logic v);
        if (is87) rx87 = v;
        else rx8 = v;
    endtask

    // Drives start, 8 data bits LSB first, and the stop bit; the line is left
    // at the stop value so callers can extend a low stop.
    task automatic send(input bit is87, input logic [7:0] b, input logic stop);
        int d;
        d = is87 ? 87 : 8;
        line(is87, 1'b0);
        tick(d);
        for (int i = 0; i < 8; i++) begin
            line(is87, b[i]);
            tick(d);
        end
        line(is87, stop);
        tick(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, fb, ob, vb, bb;
        logic [7:0] exp_q[$];
        logic       held_v;
        logic [7:0] held_d;
        int         ferr_exp, ovr_exp;

        // Reset state
        @(posedge clk);
        #1;
        tick(3);
        chk("rst_data8", d8, 8'h00);
        chk("rst_valid8", v8, 1'b0);
        chk("rst_ferr8", fe8, 1'b0);
        chk("rst_ovr8", ov8, 1'b0);
        chk("rst_busy8", bz8, 1'b0);
        chk("rst_busy87", bz87, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // 1: single byte, consumer always ready
        rdy8 = 1'b1;
        gb = got8.size(); vb = vld8; fb = ferr8; ob = ovr8;
        send(0, 8'hA5, 1'b1);
        tick(20);
        chk("t1_count", got8.size() - gb, 1);
        if (got8.size() > gb) chk("t1_data", got8[gb], 8'hA5);
        chk("t1_valid_cycles", vld8 - vb, 1);
        chk("t1_ferr", ferr8 - fb, 0);
        chk("t1_ovr", ovr8 - ob, 0);
        chk("t1_busy", bz8, 1'b0);

        // 2: 2-cycle start glitch rejected, then a real frame
        gb = got8.size(); vb = vld8; fb = ferr8; bb = busy8;
        line(0, 1'b0);
        tick(2);
        line(0, 1'b1);
        tick(12);
        chk("t2_busy_cycles", busy8 - bb, 4);
        chk("t2_busy_idle", bz8, 1'b0);
        chk("t2_valid", vld8 - vb, 0);
        chk("t2_ferr", ferr8 - fb, 0);
        send(0, 8'h3C, 1'b1);
        tick(20);
        chk("t2_count", got8.size() - gb, 1);
        if (got8.size() > gb) chk("t2_data", got8[gb], 8'h3C);

        // 3: framing error, line held low, then recovery
        gb = got8.size(); vb = vld8; fb = ferr8;
        send(0, 8'h55, 1'b0);
        tick(40);
        chk("t3_ferr_pulse", ferr8 - fb, 1);
        chk("t3_no_valid", vld8 - vb, 0);
        line(0, 1'b1);
        tick(16);
        send(0, 8'h12, 1'b1);
        tick(20);
        chk("t3_count", got8.size() - gb, 1);
        if (got8.size() > gb) chk("t3_data", got8[gb], 8'h12);
        chk("t3_ferr_total", ferr8 - fb, 1);

        // 4: overrun with consumer stalled
        rdy8 = 1'b0;
        gb = got8.size(); ob = ovr8;
        send(0, 8'h01, 1'b1);
        send(0, 8'h02, 1'b1);
        tick(10);
        chk("t4_valid", v8, 1'b1);
        chk("t4_data_held", d8, 8'h01);
        chk("t4_ovr_pulse", ovr8 - ob, 1);
        rdy8 = 1'b1;
        tick(1);
        chk("t4_valid_drop", v8, 1'b0);
        chk("t4_accept", got8.size() - gb, 1);
        if (got8.size() > gb) chk("t4_accept_data", got8[gb], 8'h01);
        rdy8 = 1'b0;

        // 5: accept on the exact completion cycle of the next byte
        gb = got8.size(); ob = ovr8;
        send(0, 8'h01, 1'b1);
        tick(5);
        fork
            send(0, 8'h02, 1'b1);
            begin
                tick(78);
                rdy8 = 1'b1;
                @(negedge clk);
                chk("t5_valid_at_cpl", v8, 1'b1);
                chk("t5_data_at_cpl", d8, 8'h01);
                @(posedge clk);
                #1;
                rdy8 = 1'b0;
                @(negedge clk);
                chk("t5_valid_after", v8, 1'b1);
                chk("t5_data_after", d8, 8'h02);
            end
        join
        tick(5);
        chk("t5_ovr", ovr8 - ob, 0);
        rdy8 = 1'b1;
        tick(3);
        chk("t5_count", got8.size() - gb, 2);
        if (got8.size() > gb + 1) chk("t5_second", got8[gb+1], 8'h02);

        // Random frame mix against byte-level holding register model
        tick(5);
        chk("rnd_start_empty", v8, 1'b0);
        gb = got8.size(); fb = ferr8; ob = ovr8;
        exp_q = {};
        held_v = 1'b0; held_d = 8'h00;
        ferr_exp = 0; ovr_exp = 0;
        for (int f = 0; f < 40; f++) begin
            int kind;
            logic r;
            logic [7:0] bv;
            kind = $urandom_range(0, 9);
            r = 1'($urandom_range(0, 1));
            bv = 8'($urandom);
            if (r && held_v) begin
                exp_q.push_back(held_d);
                held_v = 1'b0;
            end
            rdy8 = r;
            if (kind == 0) begin
                line(0, 1'b0);
                tick($urandom_range(1, 2));
                line(0, 1'b1);
                tick(6 + $urandom_range(0, 4));
            end else if (kind == 1) begin
                send(0, bv, 1'b0);
                line(0, 1'b1);
                ferr_exp++;
                tick(2 + $urandom_range(0, 6));
            end else begin
                send(0, bv, 1'b1);
                if (r) exp_q.push_back(bv);
                else if (!held_v) begin
                    held_v = 1'b1;
                    held_d = bv;
                end else ovr_exp++;
                tick($urandom_range(0, 6));
            end
        end
        if (held_v) exp_q.push_back(held_d);
        rdy8 = 1'b1;
        tick(20);
        chk("rnd_count", got8.size() - gb, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gb + i < got8.size()) chk($sformatf("rnd_byte%0d", i), got8[gb+i], exp_q[i]);
        end
        chk("rnd_ferr", ferr8 - fb, ferr_exp);
        chk("rnd_ovr", ovr8 - ob, ovr_exp);
        chk("rnd_busy_end", bz8, 1'b0);

        // 6: reset mid-frame on CLK_DIV=87, with a held byte in the other instance
        rdy8 = 1'b0;
        send(0, 8'h77, 1'b1);
        tick(4);
        chk("t6_held_before", v8, 1'b1);
        rdy87 = 1'b1;
        fork
            send(1, 8'hFF, 1'b1);
            begin
                tick(87 * 4);
                chk("t6_busy87_pre", bz87, 1'b1);
                rst_n = 1'b0;
                tick(1);
                chk("t6_rst_data87", d87, 8'h00);
                chk("t6_rst_valid87", v87, 1'b0);
                chk("t6_rst_ferr87", fe87, 1'b0);
                chk("t6_rst_ovr87", ov87, 1'b0);
                chk("t6_rst_busy87", bz87, 1'b0);
                chk("t6_rst_valid8", v8, 1'b0);
                chk("t6_rst_data8", d8, 8'h00);
                tick(3);
                rst_n = 1'b1;
            end
        join
        tick(100);
        gb = got87.size(); fb = ferr87; ob = ovr87;
        send(1, 8'h81, 1'b1);
        tick(100);
        chk("t6_count", got87.size() - gb, 1);
        if (got87.size() > gb) chk("t6_data", got87[gb], 8'h81);
        chk("t6_ferr", ferr87 - fb, 0);
        chk("t6_ovr", ovr87 - ob, 0);
        chk("t6_valid8_discarded", v8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
